// File: rtl/block_pkg.sv
// Shared definitions for block_emitter: command codes, FSM state encoding,
// ASCII constants and the length of each emitted word (trailing space included).
package block_pkg;

  typedef enum logic [1:0] {
    CMD_BEGIN = 2'b00,
    CMD_END   = 2'b01,
    CMD_OTHER = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_e;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  localparam int IDX_W = 3;

  localparam logic [IDX_W-1:0] LEN_BEGIN = 3'd6;
  localparam logic [IDX_W-1:0] LEN_END   = 3'd4;
  localparam logic [IDX_W-1:0] LEN_OTHER = 3'd2;

  localparam logic [7:0] ASCII_SPACE    = 8'h20;
  localparam logic [7:0] ASCII_B        = 8'h62;
  localparam logic [7:0] ASCII_D        = 8'h64;
  localparam logic [7:0] ASCII_E        = 8'h65;
  localparam logic [7:0] ASCII_G        = 8'h67;
  localparam logic [7:0] ASCII_I        = 8'h69;
  localparam logic [7:0] ASCII_N        = 8'h6E;
  localparam logic [7:0] ASCII_X        = 8'h78;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

endpackage

// File: rtl/block_emitter_if.sv
// Command handshake and 8-bit character stream of block_emitter.
// The emitter itself is the slave side; its driver/consumer is the master.
interface block_emitter_if;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output cmd_valid, cmd, out_ready,
    input  cmd_ready, out, out_valid
  );

  modport slave (
    input  cmd_valid, cmd, out_ready,
    output cmd_ready, out, out_valid
  );
endinterface

// File: rtl/block_emitter_rom.sv
// Character ROM: (token, idx) -> (ch, last). Define UPPERCASE_EN to emit
// "BEGIN ", "END ", "X " instead of the lowercase words.
module block_emitter_rom
  import block_pkg::*;
(
  input  cmd_e             token,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       ch,
  output logic             last
);

  logic [7:0]       letter;
  logic [IDX_W-1:0] len;

  always_comb begin
    letter = ASCII_SPACE;
    len    = LEN_OTHER;
    case (token)
      CMD_BEGIN: begin
        len = LEN_BEGIN;
        case (idx)
          3'd0:    letter = ASCII_B;
          3'd1:    letter = ASCII_E;
          3'd2:    letter = ASCII_G;
          3'd3:    letter = ASCII_I;
          3'd4:    letter = ASCII_N;
          default: letter = ASCII_SPACE;
        endcase
      end
      CMD_END: begin
        len = LEN_END;
        case (idx)
          3'd0:    letter = ASCII_E;
          3'd1:    letter = ASCII_N;
          3'd2:    letter = ASCII_D;
          default: letter = ASCII_SPACE;
        endcase
      end
      default: begin
        len    = LEN_OTHER;
        letter = (idx == 3'd0) ? ASCII_X : ASCII_SPACE;
      end
    endcase

    last = (idx == len - IDX_W'(1));

`ifdef UPPERCASE_EN
    // Every letter used is lowercase a-z, so a fixed offset folds the case.
    ch = (letter == ASCII_SPACE) ? letter : letter - ASCII_CASE_OFS;
`else
    ch = letter;
`endif
  end

endmodule

// File: rtl/block_emitter.sv
// Serialises BEGIN/END/OTHER commands as space-terminated ASCII words while
// keeping the nesting depth legal. Word case selected by UPPERCASE_EN.
module block_emitter
  import block_pkg::*;
#(
  parameter int DEPTH_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  block_emitter_if.slave     bus,
  output logic               err,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  logic [0:0]       state;
  cmd_e             token;
  logic [IDX_W-1:0] idx;
  logic [7:0]       rom_ch;
  logic             rom_last;
  logic             accept;
  logic             legal;
  logic             out_hs;

  block_emitter_rom u_rom (
    .token (token),
    .idx   (idx),
    .ch    (rom_ch),
    .last  (rom_last)
  );

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_EMIT);
  assign bus.out       = bus.out_valid ? rom_ch : 8'h00;
  assign balanced      = (depth == '0) && (state == ST_IDLE);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign out_hs        = bus.out_valid && bus.out_ready;

  // Rejection keeps the stream balanced and the depth counter from wrapping.
  always_comb begin
    legal = 1'b0;
    case (cmd_e'(bus.cmd))
      CMD_BEGIN: legal = (depth != DEPTH_MAX);
      CMD_END:   legal = (depth != '0);
      CMD_OTHER: legal = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      token <= CMD_OTHER;
      idx   <= '0;
      depth <= '0;
      err   <= 1'b0;
    end else begin
      err <= accept && !legal;
      if (accept && legal) begin
        state <= ST_EMIT;
        token <= cmd_e'(bus.cmd);
        idx   <= '0;
        if (bus.cmd == CMD_BEGIN)
          depth <= depth + DEPTH_W'(1);
        else if (bus.cmd == CMD_END)
          depth <= depth - DEPTH_W'(1);
      end else if (out_hs) begin
        if (rom_last) begin
          state <= ST_IDLE;
          idx   <= '0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_block_emitter.sv
// Bench for block_emitter: directed scenarios plus random commands and random
// out_ready, checked against a string/depth reference model.
module tb_block_emitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        err;
  logic [31:0] depth;
  logic        balanced;

  block_emitter_if bus ();

  block_emitter #(.DEPTH_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .err      (err),
    .depth    (depth),
    .balanced (balanced)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned model_depth = 0;

  function automatic string word_of(input logic [1:0] c);
    string w;
    case (c)
      2'b00:   w = "begin ";
      2'b01:   w = "end ";
      default: w = "x ";
    endcase
`ifdef UPPERCASE_EN
    w = w.toupper();
`endif
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: out_ready always high, 1: pattern 1,0,0 repeating, 2: random
  task automatic run_cmd(input logic [1:0] c, input int mode, input string tag);
    string w;
    bit    legal;
    int    k;
    int    cyc;
    int    wait_cyc;
    logic  rdy;
    logic [7:0] want;
    wait_cyc = 0;
    while (bus.cmd_ready !== 1'b1 && wait_cyc < 20) begin
      step();
      wait_cyc++;
    end
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s cmd_ready_wait: got %b want 1", tag, bus.cmd_ready);
    end
    legal = (c == 2'b00 && model_depth != 32'hFFFF_FFFF) ||
            (c == 2'b01 && model_depth != 0) || (c == 2'b10);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd       = 2'($urandom_range(3));
    if (legal && c == 2'b00) model_depth++;
    if (legal && c == 2'b01) model_depth--;

    vectors++;
    if (depth !== model_depth) begin
      miscompares++;
      $display("FAIL %s depth_after_accept: got %0d want %0d", tag, depth, model_depth);
    end
    vectors++;
    if (err !== !legal) begin
      miscompares++;
      $display("FAIL %s err_after_accept: got %b want %b", tag, err, !legal);
    end

    if (!legal) begin
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.out !== 8'h00) begin
        miscompares++;
        $display("FAIL %s reject_idle: got out_valid=%b cmd_ready=%b out=%h want 0 1 00",
                 tag, bus.out_valid, bus.cmd_ready, bus.out);
      end
      step();
      vectors++;
      if (err !== 1'b0) begin
        miscompares++;
        $display("FAIL %s err_clear: got %b want 0", tag, err);
      end
      return;
    end

    vectors++;
    if (balanced !== 1'b0) begin
      miscompares++;
      $display("FAIL %s balanced_in_flight: got %b want 0", tag, balanced);
    end

    w   = word_of(c);
    k   = 0;
    cyc = 0;
    while (k < w.len() && cyc < 60) begin
      want = w[k];
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out !== want) begin
        miscompares++;
        $display("FAIL %s char%0d cyc%0d: got valid=%b out=%h want valid=1 out=%h",
                 tag, k, cyc, bus.out_valid, bus.out, want);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(1));
      endcase
      bus.out_ready = rdy;
      step();
      cyc++;
      if (rdy) k++;
    end
    bus.out_ready = 1'b0;

    vectors++;
    if (k != w.len()) begin
      miscompares++;
      $display("FAIL %s handshakes: got %0d want %0d", tag, k, w.len());
    end
    if (mode == 0) begin
      vectors++;
      if (cyc != w.len()) begin
        miscompares++;
        $display("FAIL %s word_cycles: got %0d want %0d", tag, cyc, w.len());
      end
    end
    vectors++;
    if (bus.cmd_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s end_of_word: got cmd_ready=%b out_valid=%b want 1 0",
               tag, bus.cmd_ready, bus.out_valid);
    end
    vectors++;
    if (depth !== model_depth || balanced !== (model_depth == 0)) begin
      miscompares++;
      $display("FAIL %s end_state: got depth=%0d balanced=%b want %0d %b",
               tag, depth, balanced, model_depth, (model_depth == 0));
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd       = 2'b00;
    bus.out_ready = 1'b0;
    step();
    step();
    vectors++;
    if (bus.out !== 8'h00 || bus.out_valid !== 1'b0 || bus.cmd_ready !== 1'b1 ||
        err !== 1'b0 || depth !== 32'd0 || balanced !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_values: got out=%h ov=%b cr=%b err=%b depth=%0d bal=%b want 00 0 1 0 0 1",
               bus.out, bus.out_valid, bus.cmd_ready, err, depth, balanced);
    end
    reset       = 1'b0;
    model_depth = 0;
    step();
  endtask

  task automatic test_begin();
    run_cmd(2'b00, 0, "begin_single");
    run_cmd(2'b01, 0, "begin_single_close");
  endtask

  task automatic test_sequence();
    run_cmd(2'b00, 0, "seq_begin");
    run_cmd(2'b10, 0, "seq_other");
    run_cmd(2'b01, 0, "seq_end");
  endtask

  task automatic test_end_at_zero();
    run_cmd(2'b01, 0, "end_at_zero");
    run_cmd(2'b11, 0, "reserved_cmd");
  endtask

  task automatic test_back_to_back();
    bus.cmd_valid = 1'b1;
    bus.cmd       = 2'b01;
    step();
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_err1: got %b want 1", err);
    end
    bus.cmd = 2'b11;
    step();
    bus.cmd_valid = 1'b0;
    vectors++;
    if (err !== 1'b1 || bus.out_valid !== 1'b0 || depth !== 32'd0) begin
      miscompares++;
      $display("FAIL b2b_err2: got err=%b ov=%b depth=%0d want 1 0 0", err, bus.out_valid, depth);
    end
    step();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_err_clear: got %b want 0", err);
    end
  endtask

  task automatic test_backpressure();
    run_cmd(2'b00, 1, "bp_begin");
    run_cmd(2'b10, 1, "bp_other");
    run_cmd(2'b01, 1, "bp_end");
  endtask

  task automatic test_mid_reset();
    string w;
    logic [7:0] want;
    w = word_of(2'b00);
    want = w[2];
    bus.cmd_valid = 1'b1;
    bus.cmd       = 2'b00;
    step();
    bus.cmd_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.out !== want || depth !== model_depth + 1) begin
      miscompares++;
      $display("FAIL midreset_third_char: got out=%h depth=%0d want %h %0d",
               bus.out, depth, want, model_depth + 1);
    end
    reset = 1'b1;
    step();
    vectors++;
    if (bus.out_valid !== 1'b0 || depth !== 32'd0 || bus.cmd_ready !== 1'b1 || balanced !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_abort: got ov=%b depth=%0d cr=%b bal=%b want 0 0 1 1",
               bus.out_valid, depth, bus.cmd_ready, balanced);
    end
    reset       = 1'b0;
    model_depth = 0;
    step();
  endtask

  task automatic test_random();
    logic [1:0] c;
    for (int i = 0; i < 40; i++) begin
      c = 2'($urandom_range(3));
      if ($urandom_range(3) == 0) c = 2'b00;
      run_cmd(c, $urandom_range(2), "rand");
    end
    for (int i = 0; i < 50 && model_depth != 0; i++)
      run_cmd(2'b01, 2, "rand_drain");
    vectors++;
    if (balanced !== 1'b1 || depth !== 32'd0) begin
      miscompares++;
      $display("FAIL rand_final_balance: got bal=%b depth=%0d want 1 0", balanced, depth);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd       = 2'b00;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    test_reset();
    test_begin();
    test_sequence();
    test_end_at_zero();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/block_emitter.md
# block_emitter

Transmit-side counterpart of the block nesting checker. Accepts BEGIN/END/OTHER token commands over a valid/ready handshake and serialises each as an ASCII word plus one trailing space, one character per handshake, onto an 8-bit stream that the checker consumes. It tracks nesting depth and refuses any command that would make the emitted stream unbalanced (END at depth 0) or overflow the depth counter. The emitted stream is therefore always accepted by the checker.

## Interface
- DEPTH_W, 32, width of the nesting depth counter
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- cmd_valid  input  1  command present
- cmd  input  2  00 BEGIN, 01 END, 10 OTHER, 11 reserved
- cmd_ready  output  1  block can accept a command this cycle
- out  output  8  ASCII character being offered
- out_valid  output  1  `out` holds a valid character
- out_ready  input  1  downstream takes `out` this cycle
- err  output  1  one-cycle pulse: command accepted but rejected
- depth  output  DEPTH_W  current open-block count
- balanced  output  1  high when depth == 0 and no word is in flight

## Operation
- States: IDLE, EMIT. `cmd_ready` = (state == IDLE).
- Command accepted on a clock edge with cmd_valid && cmd_ready:
  - BEGIN, depth < 2^DEPTH_W-1: depth+1, load word "begin ", go EMIT.
  - END, depth > 0: depth-1, load word "end ", go EMIT.
  - OTHER: load word "x ", go EMIT; depth unchanged.
  - BEGIN at max depth, END at depth 0, or cmd 11: nothing emitted, depth unchanged, err = 1 for the next cycle, stay IDLE.
- EMIT: `out` = word[idx], out_valid = 1. On out_valid && out_ready: if the character is the trailing space, go IDLE; else idx+1.
- `out` and `out_valid` are held stable while out_ready is low.
- Depth changes at acceptance, before the word is emitted. `balanced` is therefore low during the whole word.
- Word lengths: BEGIN 6, END 4, OTHER 2 characters, all including the space.

## Timing
- Reset values: out = 8'h00, out_valid = 0, cmd_ready = 1, err = 0, depth = 0, balanced = 1, state IDLE, idx = 0.
- Latency: first character is valid on the cycle after acceptance.
- Throughput with out_ready held high: BEGIN takes 7 cycles from acceptance to the next cmd_ready (6 characters + 1 IDLE cycle); END takes 5; OTHER takes 3.
- err asserts in the cycle after the rejected acceptance and clears one cycle later. Back-to-back rejects give consecutive err pulses.
- No command is accepted in the same cycle as the final-character handshake.
- A reset mid-word aborts immediately. The downstream sees a truncated word, so the checker must be reset in the same cycle (system requirement).
- Depth arithmetic is unsigned DEPTH_W. It never wraps; the rejection rules guarantee this.

## Configuration
- UPPERCASE_EN defined: words emitted as "BEGIN ", "END ", "X ".
- UPPERCASE_EN undefined: lowercase "begin ", "end ", "x ".
- Timing, lengths and depth behaviour are identical in both builds.

## Structure
- Shared package block_pkg holds:
  - the command codes (CMD_BEGIN, CMD_END, CMD_OTHER)
  - the state encoding
  - ASCII constants, including space
  - the word lengths
- One sub-module, block_emitter_rom: combinational (token, idx) → (char, last). It contains the UPPERCASE_EN selection.
- The top level holds the FSM, idx, depth and the handshake logic.

## Test plan
- Reset, then BEGIN with out_ready=1 → out sequence 62 65 67 69 6E 20 over 6 cycles starting the cycle after acceptance; depth=1; balanced returns 0→0; cmd_ready high on cycle 7.
- BEGIN, OTHER, END → stream "begin x end "; final depth=0; balanced=1 after the last space; this stream fed into the checker gives result=1.
- END right after reset → err pulses for exactly 1 cycle; out_valid stays 0; depth stays 0.
- BEGIN with out_ready toggling 1,0,0,1,… → each character is held while out_ready=0; no character is dropped or duplicated; total 6 handshakes.
- Assert reset during the 3rd character of "begin " → next cycle out_valid=0, depth=0, cmd_ready=1, balanced=1.
- UPPERCASE_EN build, OTHER → out 58 then 20.
